counter_display_ctrl: RTL and testbench
=======================================

// Module: counter_display_ctrl
// PURPOSE
//  Controller for the 4-digit up/down BCD counter and its shared seven-segment display.
//  Turns debounced up/down button levels into single-step count commands.
//  Keeps four decades (0000-9999) with one synchronous carry/borrow chain.
//  Schedules the one shared decoder across the four anodes: prescaled scan, dead time,
//  optional leading-zero blanking.
// PARAMETERS
//  SCAN_DIV  50000  sysclock cycles per digit slot, dead time included (>= DEAD+2)
//  DEAD      2      cycles with all anodes off at the start of each slot
//  LZB       1      1 = blank leading zeros (digit 0 always shown); 0 = show all digits
// PORTS
//  sysclock   in   1   single clock; all state changes on its rising edge
//  reset      in   1   asynchronous, active-low; all state returns to reset values
//  up_lvl     in   1   debounced up-button level
//  down_lvl   in   1   debounced down-button level
//  clear      in   1   synchronous clear of the count, active-high
//  count      out  16  BCD count {d3,d2,d1,d0}; d0 is least significant
//  digit_sel  out  4   BCD nibble of the digit now scanned; feeds the shared decoder
//  anode      out  4   active-low anode enables; at most one bit low at any time
//  wrap_up    out  1   one-cycle pulse when 9999 -> 0000
//  wrap_dn    out  1   one-cycle pulse when 0000 -> 9999
// BEHAVIOUR
//  Reset values: count=0, digit_sel=0, anode=4'b1111, wrap_up=wrap_dn=0.
//  Internal reset values: scan index=0, prescaler=0, edge registers=0, state=DEAD.
//  Edge detect: up_q/dn_q register last cycle's level.
//   - up_rise  = up_lvl & ~up_q
//   - dn_rise  = down_lvl & ~dn_q
//  Command priority, per cycle:
//   - clear=1: count := 0; any rise that cycle is dropped.
//   - up_rise & dn_rise: no change; both rises are dropped.
//   - up_rise alone: increment. dn_rise alone: decrement.
//  Latency: count updates on the same edge that first samples the rise.
//   - New value is visible on count one cycle after up_lvl goes high.
//   - A held level gives exactly one step; a new step needs low then high again.
//  Increment:
//   - d0 += 1. A digit at 9 goes to 0 and carries into the next digit.
//   - The carry resolves combinationally within the cycle; no ripple clocks.
//   - 9999 -> 0000 asserts wrap_up for that one cycle.
//  Decrement:
//   - A digit at 0 goes to 9 and borrows from the next digit.
//   - 0000 -> 9999 asserts wrap_dn for that one cycle.
//  Digit values are always 0-9; codes 10-15 are unreachable.
//  Scan FSM, two states:
//   - DEAD: anode=1111, lasts DEAD cycles.
//   - ON: anode = ~(1<<idx), unless the digit is blanked; lasts SCAN_DIV-DEAD cycles.
//   - ON -> DEAD: idx := idx+1 mod 4. Order is 0,1,2,3,0...
//  digit_sel = digit[idx] in both states; it changes only in DEAD, giving no ghosting.
//  Blanking (LZB=1): digit k>0 is blanked when it and every higher digit are 0.
//   - A blanked slot keeps anode=1111 but still uses its full slot time.
//  Count updates mid-slot: digit_sel follows count on the next cycle; the scan is undisturbed.
//  Reset mid-operation: asynchronous return to reset values.
//   - The first slot after release is DEAD, idx=0.
// STRUCTURE
//  Shared package: BCD_MAX=4'd9, NUM_DIGITS=4, scan state encodings (DEAD/ON), ANODE_OFF=4'b1111.
//  Sub-module bcd_digit, instantiated 4x, chained by carry/borrow:
//   - inputs: inc, dec, clr, cin/bin enable
//   - outputs: value[3:0], cout, bout
//  Top level holds the edge detect, priority logic, prescaler, scan FSM and blanking.
// TESTING
//  1. Reset low then high -> count=0000, anode=1111 for DEAD cycles, then anode=1110, digit_sel=0.
//  2. up_lvl high for 10 cycles -> exactly one step (0000 -> 0001); 1 cycle later, no further change.
//  3. Preload 0999, one up rise -> 1000 next cycle, no wrap pulse. Preload 9999, up rise -> 0000 and wrap_up for 1 cycle.
//  4. At 0000, down rise -> 9999 and wrap_dn for 1 cycle. Up and down rises in the same cycle -> count unchanged.
//  5. clear=1 together with an up rise at 0042 -> 0000. With LZB=1 -> anodes 1,2,3 never low, anode0 low each 4th slot.
//  6. SCAN_DIV=8, DEAD=2, count=1234 -> anode pattern per slot 1111x2, then 1110/1101/1011/0111 x6 each.
//     digit_sel 4,3,2,1 stable across each ON window. Reset asserted mid-slot -> anode=1111 at once.

Source files
------------

// File: rtl/counter_display_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : counter_display_ctrl_pkg
//  Description : Shared constants and types for the 4-digit BCD counter and
//                its multiplexed seven-segment display controller.
//  Revision    : 1.0  initial release
// ============================================================================
package counter_display_ctrl_pkg;

    localparam logic [3:0] BCD_MAX    = 4'd9;
    localparam int         NUM_DIGITS = 4;
    localparam int         IDX_W      = $clog2(NUM_DIGITS);

    // All anodes are active-low, so "all off" is every bit high.
    localparam logic [NUM_DIGITS-1:0] ANODE_OFF = 4'b1111;

    // Scan slot phases: dead time first, then the lit window.
    typedef enum logic [0:0] {
        SCAN_DEAD = 1'b0,
        SCAN_ON   = 1'b1
    } scan_state_t;

endpackage : counter_display_ctrl_pkg
`default_nettype wire

// File: rtl/counter_display_ctrl_bcd_digit.sv
`default_nettype none
// ============================================================================
//  Module      : counter_display_ctrl_bcd_digit
//  Description : One BCD decade (0-9) with increment/decrement enables and
//                combinational carry/borrow outputs for chaining decades.
//  Revision    : 1.0  initial release
// ============================================================================
module counter_display_ctrl_bcd_digit
    import counter_display_ctrl_pkg::*;
(
    input  logic       sysclock,
    input  logic       reset,
    input  logic       inc,
    input  logic       dec,
    input  logic       clr,
    input  logic       cin,
    input  logic       bin,
    output logic [3:0] value,
    output logic       cout,
    output logic       bout
);

    logic [3:0] r_value;

    // Decade register: clear wins, then step when this decade is enabled.
    always_ff @(posedge sysclock or negedge reset) begin
        if (!reset) begin
            r_value <= 4'd0;
        end else if (clr) begin
            r_value <= 4'd0;
        end else if (inc && cin) begin
            r_value <= (r_value == BCD_MAX) ? 4'd0 : r_value + 4'd1;
        end else if (dec && bin) begin
            r_value <= (r_value == 4'd0) ? BCD_MAX : r_value - 4'd1;
        end
    end

    // Carry/borrow propagate in the same cycle so the whole chain steps on one edge.
    assign cout  = inc & cin & (r_value == BCD_MAX);
    assign bout  = dec & bin & (r_value == 4'd0);
    assign value = r_value;

endmodule : counter_display_ctrl_bcd_digit
`default_nettype wire

// File: rtl/counter_display_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : counter_display_ctrl
//  Description : Up/down 4-digit BCD counter driven by button levels, with a
//                time-multiplexed display scan (dead time, leading-zero
//                blanking) sharing one seven-segment decoder.
//  Revision    : 1.0  initial release
// ============================================================================
module counter_display_ctrl
    import counter_display_ctrl_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter int DEAD     = 2,
    parameter int LZB      = 1
) (
    input  logic                      sysclock,
    input  logic                      reset,
    input  logic                      up_lvl,
    input  logic                      down_lvl,
    input  logic                      clear,
    output logic [4*NUM_DIGITS-1:0]   count,
    output logic [3:0]                digit_sel,
    output logic [NUM_DIGITS-1:0]     anode,
    output logic                      wrap_up,
    output logic                      wrap_dn
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0]         c_presc_last = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0]         c_dead_last  = PW'(DEAD - 1);
    localparam logic [NUM_DIGITS-1:0] c_anode_lsb  = NUM_DIGITS'(1);

    logic                  r_up_q;
    logic                  r_dn_q;
    logic                  w_up_rise;
    logic                  w_dn_rise;
    logic                  w_inc;
    logic                  w_dec;

    logic [3:0]            w_digits [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] w_cin;
    logic [NUM_DIGITS-1:0] w_bin;
    logic [NUM_DIGITS-1:0] w_cout;
    logic [NUM_DIGITS-1:0] w_bout;
    logic [NUM_DIGITS-1:0] w_blank;

    logic                  r_wrap_up;
    logic                  r_wrap_dn;

    scan_state_t           r_state;
    scan_state_t           w_state_next;
    logic [PW-1:0]         r_presc;
    logic [PW-1:0]         w_presc_next;
    logic [IDX_W-1:0]      r_idx;
    logic [IDX_W-1:0]      w_idx_next;
    logic [3:0]            r_digit_sel;

    // Remember last cycle's button levels so only a low-to-high step counts.
    always_ff @(posedge sysclock or negedge reset) begin
        if (!reset) begin
            r_up_q <= 1'b0;
            r_dn_q <= 1'b0;
        end else begin
            r_up_q <= up_lvl;
            r_dn_q <= down_lvl;
        end
    end

    assign w_up_rise = up_lvl & ~r_up_q;
    assign w_dn_rise = down_lvl & ~r_dn_q;

    // Clear beats any rise; simultaneous up and down rises cancel each other.
    assign w_inc = ~clear & w_up_rise & ~w_dn_rise;
    assign w_dec = ~clear & w_dn_rise & ~w_up_rise;

    // The least significant decade always steps; higher ones follow the chain.
    assign w_cin = {w_cout[NUM_DIGITS-2:0], 1'b1};
    assign w_bin = {w_bout[NUM_DIGITS-2:0], 1'b1};

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
        counter_display_ctrl_bcd_digit u_digit (
            .sysclock (sysclock),
            .reset    (reset),
            .inc      (w_inc),
            .dec      (w_dec),
            .clr      (clear),
            .cin      (w_cin[k]),
            .bin      (w_bin[k]),
            .value    (w_digits[k]),
            .cout     (w_cout[k]),
            .bout     (w_bout[k])
        );
        assign count[4*k +: 4] = w_digits[k];
    end

    // Wrap pulses line up with the cycle in which the wrapped count appears.
    always_ff @(posedge sysclock or negedge reset) begin
        if (!reset) begin
            r_wrap_up <= 1'b0;
            r_wrap_dn <= 1'b0;
        end else begin
            r_wrap_up <= w_cout[NUM_DIGITS-1];
            r_wrap_dn <= w_bout[NUM_DIGITS-1];
        end
    end

    assign wrap_up = r_wrap_up;
    assign wrap_dn = r_wrap_dn;

    // Leading-zero blanking: a digit is dark when it and all higher digits are zero.
    always_comb begin
        logic seen_nz;
        w_blank = '0;
        seen_nz = 1'b0;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            seen_nz    = seen_nz | (w_digits[k] != 4'd0);
            w_blank[k] = (LZB != 0) && !seen_nz;
        end
    end

    // Scan state, prescaler and digit index registers.
    always_ff @(posedge sysclock or negedge reset) begin
        if (!reset) begin
            r_state <= SCAN_DEAD;
            r_presc <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_next;
            r_presc <= w_presc_next;
            r_idx   <= w_idx_next;
        end
    end

    // Slot sequencing and anode drive; index advances only when entering dead time.
    always_comb begin
        w_state_next = r_state;
        w_presc_next = (r_presc == c_presc_last) ? '0 : r_presc + PW'(1);
        w_idx_next   = r_idx;
        anode        = ANODE_OFF;
        case (r_state)
            SCAN_DEAD: begin
                if (r_presc == c_dead_last) begin
                    w_state_next = SCAN_ON;
                end
            end
            SCAN_ON: begin
                if (!w_blank[r_idx]) begin
                    anode = ~(c_anode_lsb << r_idx);
                end
                if (r_presc == c_presc_last) begin
                    w_state_next = SCAN_DEAD;
                    w_idx_next   = r_idx + IDX_W'(1);
                end
            end
            default: begin
                w_state_next = SCAN_DEAD;
            end
        endcase
    end

    // Decoder input tracks the upcoming index so it switches on entry to dead time.
    always_ff @(posedge sysclock or negedge reset) begin
        if (!reset) begin
            r_digit_sel <= 4'd0;
        end else begin
            r_digit_sel <= w_digits[w_idx_next];
        end
    end

    assign digit_sel = r_digit_sel;

endmodule : counter_display_ctrl
`default_nettype wire

// File: tb/tb_counter_display_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_counter_display_ctrl
//  Description : Directed self-checking bench for counter_display_ctrl with a
//                short scan period (SCAN_DIV=8, DEAD=2, LZB=1).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_counter_display_ctrl;

    logic        sysclock;
    logic        reset;
    logic        up_lvl;
    logic        down_lvl;
    logic        clear;
    logic [15:0] count;
    logic [3:0]  digit_sel;
    logic [3:0]  anode;
    logic        wrap_up;
    logic        wrap_dn;

    int n_vec;
    int n_err;

    counter_display_ctrl #(
        .SCAN_DIV (8),
        .DEAD     (2),
        .LZB      (1)
    ) dut (
        .sysclock  (sysclock),
        .reset     (reset),
        .up_lvl    (up_lvl),
        .down_lvl  (down_lvl),
        .clear     (clear),
        .count     (count),
        .digit_sel (digit_sel),
        .anode     (anode),
        .wrap_up   (wrap_up),
        .wrap_dn   (wrap_dn)
    );

    initial sysclock = 1'b0;
    always #5 sysclock = ~sysclock;

    // One up step: rise for one cycle, then low; returns after the step is visible.
    task automatic step_up();
        @(negedge sysclock) up_lvl = 1'b1;
        @(negedge sysclock) up_lvl = 1'b0;
    endtask

    // Release reset at a negedge and check the first slot is dead time on digit 0.
    task automatic release_and_check(input string tag);
        @(negedge sysclock) reset = 1'b1;
        #1;
        n_vec++;
        if (anode !== 4'b1111) begin
            $display("FAIL %s_dead0: anode=%b expected=%b", tag, anode, 4'b1111); n_err++;
        end
        @(negedge sysclock);
        n_vec++;
        if (anode !== 4'b1111) begin
            $display("FAIL %s_dead1: anode=%b expected=%b", tag, anode, 4'b1111); n_err++;
        end
        @(negedge sysclock);
        n_vec++;
        if (anode !== 4'b1110 || digit_sel !== 4'd0) begin
            $display("FAIL %s_on0: anode=%b digit_sel=%0d expected anode=1110 digit_sel=0",
                     tag, anode, digit_sel); n_err++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; up_lvl = 1'b0; down_lvl = 1'b0; clear = 1'b0;
        repeat (3) @(negedge sysclock);
        n_vec++;
        if (count !== 16'h0000 || anode !== 4'b1111 || digit_sel !== 4'd0 ||
            wrap_up !== 1'b0 || wrap_dn !== 1'b0) begin
            $display("FAIL reset_values: count=%h anode=%b digit_sel=%0d wrap_up=%b wrap_dn=%b expected 0000/1111/0/0/0",
                     count, anode, digit_sel, wrap_up, wrap_dn); n_err++;
        end
        release_and_check("reset");
    endtask

    task automatic test_single_step();
        @(negedge sysclock) up_lvl = 1'b1;
        @(negedge sysclock);
        n_vec++;
        if (count !== 16'h0001) begin
            $display("FAIL single_step: count=%h expected=%h", count, 16'h0001); n_err++;
        end
        repeat (9) @(negedge sysclock);
        n_vec++;
        if (count !== 16'h0001) begin
            $display("FAIL held_level: count=%h expected=%h", count, 16'h0001); n_err++;
        end
        up_lvl = 1'b0;
        @(negedge sysclock);
        n_vec++;
        if (count !== 16'h0001) begin
            $display("FAIL after_release: count=%h expected=%h", count, 16'h0001); n_err++;
        end
    endtask

    task automatic test_carry();
        repeat (998) step_up();
        n_vec++;
        if (count !== 16'h0999) begin
            $display("FAIL preload_0999: count=%h expected=%h", count, 16'h0999); n_err++;
        end
        @(negedge sysclock) up_lvl = 1'b1;
        @(negedge sysclock);
        n_vec++;
        if (count !== 16'h1000 || wrap_up !== 1'b0) begin
            $display("FAIL carry_chain: count=%h wrap_up=%b expected=1000/0", count, wrap_up); n_err++;
        end
        up_lvl = 1'b0;
    endtask

    task automatic test_wrap_dn();
        @(negedge sysclock) clear = 1'b1;
        @(negedge sysclock) clear = 1'b0;
        n_vec++;
        if (count !== 16'h0000) begin
            $display("FAIL clear: count=%h expected=%h", count, 16'h0000); n_err++;
        end
        @(negedge sysclock) down_lvl = 1'b1;
        @(negedge sysclock);
        n_vec++;
        if (count !== 16'h9999 || wrap_dn !== 1'b1 || wrap_up !== 1'b0) begin
            $display("FAIL wrap_dn_step: count=%h wrap_dn=%b wrap_up=%b expected=9999/1/0",
                     count, wrap_dn, wrap_up); n_err++;
        end
        down_lvl = 1'b0;
        @(negedge sysclock);
        n_vec++;
        if (count !== 16'h9999 || wrap_dn !== 1'b0) begin
            $display("FAIL wrap_dn_pulse: count=%h wrap_dn=%b expected=9999/0", count, wrap_dn); n_err++;
        end
    endtask

    task automatic test_both_rises();
        @(negedge sysclock) begin up_lvl = 1'b1; down_lvl = 1'b1; end
        @(negedge sysclock);
        n_vec++;
        if (count !== 16'h9999 || wrap_up !== 1'b0 || wrap_dn !== 1'b0) begin
            $display("FAIL both_rises: count=%h wrap_up=%b wrap_dn=%b expected=9999/0/0",
                     count, wrap_up, wrap_dn); n_err++;
        end
        up_lvl = 1'b0; down_lvl = 1'b0;
        @(negedge sysclock);
    endtask

    task automatic test_wrap_up();
        @(negedge sysclock) up_lvl = 1'b1;
        @(negedge sysclock);
        n_vec++;
        if (count !== 16'h0000 || wrap_up !== 1'b1 || wrap_dn !== 1'b0) begin
            $display("FAIL wrap_up_step: count=%h wrap_up=%b wrap_dn=%b expected=0000/1/0",
                     count, wrap_up, wrap_dn); n_err++;
        end
        up_lvl = 1'b0;
        @(negedge sysclock);
        n_vec++;
        if (count !== 16'h0000 || wrap_up !== 1'b0) begin
            $display("FAIL wrap_up_pulse: count=%h wrap_up=%b expected=0000/0", count, wrap_up); n_err++;
        end
    endtask

    task automatic test_clear_priority();
        repeat (42) step_up();
        n_vec++;
        if (count !== 16'h0042) begin
            $display("FAIL preload_0042: count=%h expected=%h", count, 16'h0042); n_err++;
        end
        @(negedge sysclock) begin clear = 1'b1; up_lvl = 1'b1; end
        @(negedge sysclock) clear = 1'b0;
        n_vec++;
        if (count !== 16'h0000) begin
            $display("FAIL clear_over_up: count=%h expected=%h", count, 16'h0000); n_err++;
        end
        @(negedge sysclock);
        n_vec++;
        if (count !== 16'h0000) begin
            $display("FAIL dropped_rise: count=%h expected=%h", count, 16'h0000); n_err++;
        end
        up_lvl = 1'b0;
        @(negedge sysclock);
    endtask

    // At 0000 with blanking, only anode 0 ever lights: 6 of every 32 cycles.
    task automatic test_lzb();
        int upper_low;
        int a0_low;
        upper_low = 0;
        a0_low    = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge sysclock);
            if (anode[3:1] !== 3'b111) upper_low++;
            if (anode === 4'b1110) a0_low++;
        end
        n_vec++;
        if (upper_low !== 0) begin
            $display("FAIL lzb_upper: cycles_with_upper_low=%0d expected=0", upper_low); n_err++;
        end
        n_vec++;
        if (a0_low !== 12) begin
            $display("FAIL lzb_anode0: low_cycles=%0d expected=12", a0_low); n_err++;
        end
    endtask

    task automatic test_scan();
        int  guard;
        int  bad;
        logic [3:0] exp_an;
        repeat (1234) step_up();
        n_vec++;
        if (count !== 16'h1234) begin
            $display("FAIL preload_1234: count=%h expected=%h", count, 16'h1234); n_err++;
        end
        // Align to the start of slot 0: find digit 3 lit, then the next dead cycle.
        guard = 0;
        while (anode !== 4'b0111 && guard < 40) begin @(negedge sysclock); guard++; end
        while (anode !== 4'b1111 && guard < 50) begin @(negedge sysclock); guard++; end
        n_vec++;
        if (guard >= 40) begin
            $display("FAIL scan_sync: cycles_waited=%0d expected<40", guard); n_err++;
        end
        for (int s = 0; s < 4; s++) begin
            bad = 0;
            for (int c = 0; c < 8; c++) begin
                if (!(s == 0 && c == 0)) @(negedge sysclock);
                exp_an = (c < 2) ? 4'b1111 : (4'b1111 ^ (4'b0001 << s));
                if (anode !== exp_an) bad++;
                if (c >= 2 && digit_sel !== 4'(4 - s)) bad++;
            end
            n_vec++;
            if (bad !== 0) begin
                $display("FAIL scan_slot%0d: bad_cycles=%0d expected=0 (last anode=%b digit_sel=%0d)",
                         s, bad, anode, digit_sel); n_err++;
            end
        end
    endtask

    task automatic test_reset_mid();
        int guard;
        guard = 0;
        while (anode === 4'b1111 && guard < 40) begin @(negedge sysclock); guard++; end
        n_vec++;
        if (anode === 4'b1111) begin
            $display("FAIL midreset_sync: anode=%b expected a lit digit", anode); n_err++;
        end
        #2 reset = 1'b0;
        #1;
        n_vec++;
        if (anode !== 4'b1111 || count !== 16'h0000 || digit_sel !== 4'd0) begin
            $display("FAIL midreset_async: anode=%b count=%h digit_sel=%0d expected 1111/0000/0",
                     anode, count, digit_sel); n_err++;
        end
        release_and_check("midreset");
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_single_step();
        test_carry();
        test_wrap_dn();
        test_both_rises();
        test_wrap_up();
        test_clear_priority();
        test_lzb();
        test_scan();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_counter_display_ctrl
`default_nettype wire
